// File: rtl/vga_raster_n.sv
// vga_raster_n: VGA sync generator and N_OBJ-square renderer over a background, RGB332 out; VGA_OBJ_COLLIDE_EN adds object-0 collision flags.
// Latency: one pixel-enable (pe) stage; sync, colour and coordinates are registered together on the same pe.
// Backpressure: none; free-running raster, object positions sampled once per frame at the start of vertical blank.
module vga_raster_n #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int N_OBJ    = 3,
    parameter int OBJ_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [N_OBJ*10-1:0]   obj_x,
    input  logic [N_OBJ*10-1:0]   obj_y,
    input  logic [N_OBJ*8-1:0]    obj_color,
    input  logic [7:0]            bg_color,
    output logic                  hsync,
    output logic                  vsync,
    output logic [2:0]            red,
    output logic [2:0]            green,
    output logic [1:0]            blue,
    output logic [9:0]            pix_x,
    output logic [9:0]            pix_y,
    output logic                  frame_start,
    output logic [N_OBJ-2:0]      collide
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    logic [DIV_W-1:0]      div_q, div_d;
    logic                  pe;
    logic [9:0]            hc_q, hc_d;
    logic [9:0]            vc_q, vc_d;
    logic                  latch;
    logic [N_OBJ*10-1:0]   sx_q, sx_d;
    logic [N_OBJ*10-1:0]   sy_q, sy_d;
    logic [N_OBJ-1:0]      hit;
    logic                  active;
    logic [7:0]            pix_color;
    logic                  hsync_nxt, vsync_nxt;

    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic [7:0]            rgb_q, rgb_d;
    logic [9:0]            pix_x_q, pix_x_d;
    logic [9:0]            pix_y_q, pix_y_d;
    logic                  frame_start_q, frame_start_d;

    assign pe = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = pe ? '0 : div_q + 1'b1;
    end

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pe) begin
            if (hc_q == 10'(H_TOTAL - 1)) begin
                hc_d = '0;
                vc_d = (vc_q == 10'(V_TOTAL - 1)) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // Positions are captured once per frame, at the first pe of vertical blank.
    assign latch = pe && (hc_q == '0) && (vc_q == 10'(V_ACTIVE));

    always_comb begin
        sx_d = latch ? obj_x : sx_q;
        sy_d = latch ? obj_y : sy_q;
    end

    // 11-bit compare keeps objects near coordinate 1023 from wrapping onto the left/top edge.
    for (genvar i = 0; i < N_OBJ; i++) begin : g_hit
        logic [10:0] ox;
        logic [10:0] oy;
        assign ox = {1'b0, sx_q[10*i +: 10]};
        assign oy = {1'b0, sy_q[10*i +: 10]};
        assign hit[i] = (ox <= {1'b0, hc_q}) && ({1'b0, hc_q} < ox + 11'(OBJ_SIZE)) &&
                        (oy <= {1'b0, vc_q}) && ({1'b0, vc_q} < oy + 11'(OBJ_SIZE));
    end

    assign active = (hc_q < 10'(H_ACTIVE)) && (vc_q < 10'(V_ACTIVE));

    always_comb begin
        pix_color = bg_color;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (hit[i]) pix_color = obj_color[8*i +: 8];
        end
        if (!active) pix_color = '0;
    end

    assign hsync_nxt = !((hc_q >= 10'(H_ACTIVE + H_FP)) && (hc_q < 10'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_nxt = !((vc_q >= 10'(V_ACTIVE + V_FP)) && (vc_q < 10'(V_ACTIVE + V_FP + V_SYNC)));

    always_comb begin
        hsync_d       = pe ? hsync_nxt : hsync_q;
        vsync_d       = pe ? vsync_nxt : vsync_q;
        rgb_d         = pe ? pix_color : rgb_q;
        pix_x_d       = pe ? hc_q : pix_x_q;
        pix_y_d       = pe ? vc_q : pix_y_q;
        frame_start_d = pe && (hc_q == '0) && (vc_q == '0);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            div_q         <= '0;
            hc_q          <= '0;
            vc_q          <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = rgb_q[7:5];
    assign green       = rgb_q[4:2];
    assign blue        = rgb_q[1:0];
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;

`ifdef VGA_OBJ_COLLIDE_EN
    logic [N_OBJ-2:0] pair_hit;
    logic [N_OBJ-2:0] acc_q, acc_d;
    logic [N_OBJ-2:0] collide_q, collide_d;

    // A hit on the latch pe itself belongs to the frame that is starting.
    always_comb begin
        pair_hit = '0;
        for (int i = 1; i < N_OBJ; i++) begin
            pair_hit[i-1] = pe && active && hit[0] && hit[i];
        end
        acc_d     = latch ? pair_hit : (acc_q | pair_hit);
        collide_d = latch ? acc_q : collide_q;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc_q     <= '0;
            collide_q <= '0;
        end else begin
            acc_q     <= acc_d;
            collide_q <= collide_d;
        end
    end

    assign collide = collide_q;
`else
    assign collide = '0;
`endif

endmodule

// File: tb/tb_vga_raster_n.sv
// Bench for vga_raster_n on a reduced raster; a pixel-index/rectangle model predicts every output.
`timescale 1ns/1ps
module tb_vga_raster_n;

    localparam int HA = 32, HF = 4, HS = 4, HB = 4;
    localparam int VA = 24, VF = 2, VS = 2, VB = 2;
    localparam int CD = 3, NO = 3, OS = 6;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT * CD;
    localparam int VW = 30 + NO;
    localparam logic [VW-1:0] RST_VEC = {1'b1, 1'b1, 8'h00, 10'd0, 10'd0, 1'b0, {(NO-1){1'b0}}};

    logic              clk = 1'b0;
    logic              clr_n = 1'b0;
    logic [NO*10-1:0]  obj_x = '0;
    logic [NO*10-1:0]  obj_y = '0;
    logic [NO*8-1:0]   obj_color = '0;
    logic [7:0]        bg_color = '0;
    logic              hsync, vsync, frame_start;
    logic [2:0]        red, green;
    logic [1:0]        blue;
    logic [9:0]        pix_x, pix_y;
    logic [NO-2:0]     collide;

    int n_checks = 0;
    int n_errors = 0;

    vga_raster_n #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CD), .N_OBJ(NO), .OBJ_SIZE(OS)
    ) dut (
        .clk(clk), .clr_n(clr_n),
        .obj_x(obj_x), .obj_y(obj_y), .obj_color(obj_color), .bg_color(bg_color),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .collide(collide)
    );

    always #5 clk = ~clk;

    // Model: the k-th clk edge since reset release that is a multiple of CD presents pixel k-1 in raster order.
    int            ecnt = 0;
    int            m_sx [NO];
    int            m_sy [NO];
    logic [NO-2:0] m_col = '0;

    function automatic logic [NO-2:0] overlap_model();
        logic [NO-2:0] r;
        int xl, xh, yl, yh;
        r = '0;
        for (int i = 1; i < NO; i++) begin
            xl = (m_sx[0] > m_sx[i]) ? m_sx[0] : m_sx[i];
            xh = (m_sx[0] < m_sx[i]) ? m_sx[0] + OS : m_sx[i] + OS;
            yl = (m_sy[0] > m_sy[i]) ? m_sy[0] : m_sy[i];
            yh = (m_sy[0] < m_sy[i]) ? m_sy[0] + OS : m_sy[i] + OS;
            if (xh > HA) xh = HA;
            if (yh > VA) yh = VA;
            r[i-1] = (xl < xh) && (yl < yh);
        end
        return r;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ecnt  <= 0;
            m_col <= '0;
            for (int i = 0; i < NO; i++) begin
                m_sx[i] <= 0;
                m_sy[i] <= 0;
            end
        end else begin
            ecnt <= ecnt + 1;
            if (((ecnt + 1) % CD == 0) && ((((ecnt + 1) / CD) - 1) % (HT * VT) == VA * HT)) begin
                m_col <= overlap_model();
                for (int i = 0; i < NO; i++) begin
                    m_sx[i] <= int'(obj_x[10*i +: 10]);
                    m_sy[i] <= int'(obj_y[10*i +: 10]);
                end
            end
        end
    end

    function automatic int cur_p();
        return ((ecnt / CD) - 1) % (HT * VT);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        int p, eh, ev;
        logic hs, vs, fs;
        logic [7:0] c;
        logic [NO-2:0] col;
`ifdef VGA_OBJ_COLLIDE_EN
        col = m_col;
`else
        col = '0;
`endif
        if (ecnt / CD == 0) return {1'b1, 1'b1, 8'h00, 10'd0, 10'd0, 1'b0, col};
        p  = cur_p();
        eh = p % HT;
        ev = p / HT;
        hs = !((eh >= HA + HF) && (eh < HA + HF + HS));
        vs = !((ev >= VA + VF) && (ev < VA + VF + VS));
        c  = 8'h00;
        if (eh < HA && ev < VA) begin
            c = bg_color;
            for (int i = NO - 1; i >= 0; i--) begin
                if (eh >= m_sx[i] && eh < m_sx[i] + OS && ev >= m_sy[i] && ev < m_sy[i] + OS)
                    c = obj_color[8*i +: 8];
            end
        end
        fs = (ecnt % CD == 0) && (p == 0);
        return {hs, vs, c, 10'(eh), 10'(ev), fs, col};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {hsync, vsync, red, green, blue, pix_x, pix_y, frame_start, collide};
    endfunction

    task automatic set_obj(input int i, input int x, input int y, input logic [7:0] c);
        obj_x[10*i +: 10]    = 10'(x);
        obj_y[10*i +: 10]    = 10'(y);
        obj_color[8*i +: 8]  = c;
    endtask

    // Advance until the model says pixel (x,y) has just been presented.
    task automatic run_to(input int x, input int y);
        bit found = 0;
        int guard = 0;
        while (!found && guard < FRAME + 4 * CD) begin
            @(negedge clk);
            guard++;
            if (ecnt >= CD && ecnt % CD == 0 && cur_p() % HT == x && cur_p() / HT == y) found = 1;
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_to_timeout: pixel (%0d,%0d) not reached within %0d clk", x, y, guard);
        end
    endtask

    task automatic test_reset();
        set_obj(0, 0, 0, 8'h1C);
        set_obj(1, 0, 0, 8'h03);
        set_obj(2, 0, 0, 8'hE0);
        bg_color = 8'h49;
        clr_n = 1'b0;
        #7;
        n_checks++;
        if (dut_vec() !== RST_VEC) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), RST_VEC);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== RST_VEC) begin
            n_errors++;
            $display("FAIL reset_held: got %h expected %h", dut_vec(), RST_VEC);
        end
        @(negedge clk);
        clr_n = 1'b1;
        for (int e = 1; e <= CD + 1; e++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (frame_start !== (e == CD)) begin
                n_errors++;
                $display("FAIL reset_first_pe: edge %0d frame_start got %b expected %b", e, frame_start, e == CD);
            end
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL reset_release_vec: edge %0d got %h expected %h", e, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({red, green, blue} !== 8'h1C) begin
            n_errors++;
            $display("FAIL reset_zero_shadow_pixel: got %h expected 1c", {red, green, blue});
        end
    endtask

    task automatic test_sync_timing();
        int hs_start = -1, hs_len = -1, vs_start = -1, vs_len = -1;
        int hs_run = 0, vs_run = 0, fs_cnt = 0, fs_t0 = -1, fs_t1 = -1, fs_wide = 0;
        logic hs_prev = 1'b1, vs_prev = 1'b1, fs_prev = 1'b0;
        for (int t = 0; t < 2 * FRAME; t++) begin
            @(negedge clk);
            if (hs_prev && !hsync && hs_start < 0) hs_start = int'(pix_x);
            if (!hs_prev && hsync && hs_start >= 0 && hs_len < 0) hs_len = hs_run;
            hs_run = hsync ? 0 : hs_run + 1;
            if (vs_prev && !vsync && vs_start < 0) vs_start = int'(pix_y);
            if (!vs_prev && vsync && vs_start >= 0 && vs_len < 0) vs_len = vs_run;
            vs_run = vsync ? 0 : vs_run + 1;
            if (frame_start && !fs_prev) begin
                fs_cnt++;
                if (fs_t0 < 0) fs_t0 = t;
                else if (fs_t1 < 0) fs_t1 = t;
            end
            if (frame_start && fs_prev) fs_wide++;
            hs_prev = hsync;
            vs_prev = vsync;
            fs_prev = frame_start;
        end
        n_checks++;
        if (hs_start !== HA + HF) begin n_errors++; $display("FAIL hsync_start: got %0d expected %0d", hs_start, HA + HF); end
        n_checks++;
        if (hs_len !== HS * CD) begin n_errors++; $display("FAIL hsync_width: got %0d expected %0d", hs_len, HS * CD); end
        n_checks++;
        if (vs_start !== VA + VF) begin n_errors++; $display("FAIL vsync_start: got %0d expected %0d", vs_start, VA + VF); end
        n_checks++;
        if (vs_len !== VS * HT * CD) begin n_errors++; $display("FAIL vsync_width: got %0d expected %0d", vs_len, VS * HT * CD); end
        n_checks++;
        if (fs_cnt !== 2) begin n_errors++; $display("FAIL frame_start_count: got %0d expected 2", fs_cnt); end
        n_checks++;
        if (fs_t1 - fs_t0 !== FRAME) begin n_errors++; $display("FAIL frame_period: got %0d expected %0d", fs_t1 - fs_t0, FRAME); end
        n_checks++;
        if (fs_wide !== 0) begin n_errors++; $display("FAIL frame_start_width: got %0d extra cycles expected 0", fs_wide); end
    endtask

    task automatic test_background();
        bg_color = 8'hE0;
        for (int i = 0; i < NO; i++) set_obj(i, 700, $urandom_range(0, VA), 8'($urandom));
        run_to(1, VA);
        run_to(5, 5);
        n_checks++;
        if ({red, green, blue} !== 8'hE0) begin
            n_errors++;
            $display("FAIL bg_active: got r%0d g%0d b%0d expected r7 g0 b0", red, green, blue);
        end
        run_to(HA + 1, 6);
        n_checks++;
        if ({red, green, blue} !== 8'h00) begin
            n_errors++;
            $display("FAIL bg_hblank: got %h expected 00", {red, green, blue});
        end
        run_to(3, VA + 1);
        n_checks++;
        if ({red, green, blue} !== 8'h00) begin
            n_errors++;
            $display("FAIL bg_vblank: got %h expected 00", {red, green, blue});
        end
        for (int s = 0; s < 30; s++) begin
            repeat ($urandom_range(1, 90)) @(negedge clk);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL bg_sample: got %h expected %h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_priority();
        bg_color = 8'h49;
        set_obj(0, 4, 4, 8'h1C);
        set_obj(1, 7, 7, 8'h03);
        set_obj(2, 900, 2, 8'hE0);
        run_to(1, VA);
        run_to(8, 8);
        n_checks++;
        if ({red, green, blue} !== 8'h1C) begin n_errors++; $display("FAIL prio_overlap: got %h expected 1c", {red, green, blue}); end
        run_to(11, 11);
        n_checks++;
        if ({red, green, blue} !== 8'h03) begin n_errors++; $display("FAIL prio_obj1: got %h expected 03", {red, green, blue}); end
        run_to(13, 13);
        n_checks++;
        if ({red, green, blue} !== 8'h49) begin n_errors++; $display("FAIL prio_bg: got %h expected 49", {red, green, blue}); end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin n_errors++; $display("FAIL prio_vec: got %h expected %h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_collide();
        logic [NO-2:0] hit_c, clear_c;
`ifdef VGA_OBJ_COLLIDE_EN
        hit_c = 2'b01;
`else
        hit_c = 2'b00;
`endif
        clear_c = 2'b00;
        run_to(1, VA);
        n_checks++;
        if (collide !== hit_c) begin n_errors++; $display("FAIL collide_set: got %b expected %b", collide, hit_c); end
        set_obj(1, 20, 16, 8'h03);
        run_to(1, VA);
        n_checks++;
        if (collide !== hit_c) begin n_errors++; $display("FAIL collide_hold_old_frame: got %b expected %b", collide, hit_c); end
        run_to(20, 5);
        n_checks++;
        if (collide !== hit_c) begin n_errors++; $display("FAIL collide_stable_in_frame: got %b expected %b", collide, hit_c); end
        run_to(1, VA);
        n_checks++;
        if (collide !== clear_c) begin n_errors++; $display("FAIL collide_clear: got %b expected %b", collide, clear_c); end
    endtask

    task automatic test_shadow();
        run_to(0, 5);
        set_obj(0, 20, 4, 8'h1C);
        run_to(5, 7);
        n_checks++;
        if ({red, green, blue} !== 8'h1C) begin n_errors++; $display("FAIL shadow_old_pos: got %h expected 1c", {red, green, blue}); end
        run_to(21, 7);
        n_checks++;
        if ({red, green, blue} !== 8'h49) begin n_errors++; $display("FAIL shadow_new_pos_early: got %h expected 49", {red, green, blue}); end
        run_to(1, VA);
        run_to(5, 7);
        n_checks++;
        if ({red, green, blue} !== 8'h49) begin n_errors++; $display("FAIL shadow_old_pos_cleared: got %h expected 49", {red, green, blue}); end
        run_to(21, 7);
        n_checks++;
        if ({red, green, blue} !== 8'h1C) begin n_errors++; $display("FAIL shadow_new_pos: got %h expected 1c", {red, green, blue}); end
    endtask

    task automatic test_edge_objects();
        set_obj(0, HA - 2, VA - 2, 8'h1C);
        set_obj(1, 1020, 3, 8'h03);
        set_obj(2, 5, 1021, 8'hE0);
        run_to(1, VA);
        run_to(6, 1);
        n_checks++;
        if ({red, green, blue} !== 8'h49) begin n_errors++; $display("FAIL edge_no_wrap_y: got %h expected 49", {red, green, blue}); end
        run_to(0, 4);
        n_checks++;
        if ({red, green, blue} !== 8'h49) begin n_errors++; $display("FAIL edge_no_wrap_x: got %h expected 49", {red, green, blue}); end
        run_to(HA - 1, VA - 1);
        n_checks++;
        if ({red, green, blue} !== 8'h1C) begin n_errors++; $display("FAIL edge_clipped_obj: got %h expected 1c", {red, green, blue}); end
        run_to(HA, VA - 1);
        n_checks++;
        if ({red, green, blue} !== 8'h00) begin n_errors++; $display("FAIL edge_clip_blank: got %h expected 00", {red, green, blue}); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            bg_color = 8'($urandom);
            for (int i = 0; i < NO; i++)
                set_obj(i, $urandom_range(0, HA + 4), $urandom_range(0, VA + 4), 8'($urandom));
            run_to(1, VA);
            for (int s = 0; s < 40; s++) begin
                repeat ($urandom_range(1, 120)) @(negedge clk);
                n_checks++;
                if (dut_vec() !== exp_vec()) begin
                    n_errors++;
                    $display("FAIL random_sample: frame %0d got %h expected %h", f, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        run_to(HA / 2, VA / 2);
        #2;
        clr_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== RST_VEC) begin
            n_errors++;
            $display("FAIL midreset_async: got %h expected %h", dut_vec(), RST_VEC);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        for (int e = 1; e <= CD + 1; e++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (frame_start !== (e == CD)) begin
                n_errors++;
                $display("FAIL midreset_first_pe: edge %0d frame_start got %b expected %b", e, frame_start, e == CD);
            end
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL midreset_vec: edge %0d got %h expected %h", e, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sync_timing();
        test_background();
        test_priority();
        test_collide();
        test_shadow();
        test_edge_objects();
        test_random_frames();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
